// File: rtl/sha512_padder_if.sv
// rtl/sha512_padder_if.sv - byte-in / block-out handshake bundle for the SHA-512 padder
interface sha512_padder_if #(
  parameter int BLOCK_W = 1024
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_block, out_last
  );
endinterface

// File: rtl/sha512_padder.sv
// rtl/sha512_padder.sv - FIPS 180-4 SHA-512 message padder, byte stream in, 1024-bit blocks out
module sha512_padder #(
  parameter int CNT_W   = 32,
  parameter int BLOCK_W = 1024
) (
  input logic            clk,
  input logic            rst_n,
  sha512_padder_if.slave bus
);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_OUT  = 1'b1;

  localparam logic [1:0] P_NONE     = 2'd0;
  localparam logic [1:0] P_LEN_ONLY = 2'd1;
  localparam logic [1:0] P_MARK_LEN = 2'd2;

  logic [0:0]         state;
  logic [6:0]         idx;
  logic [CNT_W-1:0]   count;
  logic [1:0]         pending;
  logic [BLOCK_W-1:0] blk;
  logic               last_r;

  logic [7:0]         p;
  logic [9:0]         hi_k;
  logic [9:0]         hi_p;
  logic [CNT_W-1:0]   count_n;
  logic [127:0]       len_new;
  logic [127:0]       len_cur;

  assign p       = {1'b0, idx} + 8'd1;
  assign hi_k    = 10'd1023 - {idx, 3'b000};
  assign hi_p    = 10'd1023 - {p[6:0], 3'b000};
  assign count_n = count + CNT_W'(1);
  assign len_new = 128'({count_n, 3'b000});
  assign len_cur = 128'({count, 3'b000});

  assign bus.in_ready  = (state == S_FILL);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_block = blk;
  assign bus.out_last  = last_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FILL;
      idx     <= '0;
      count   <= '0;
      pending <= P_NONE;
      blk     <= '0;
      last_r  <= 1'b0;
    end else if (state == S_FILL) begin
      if (bus.in_valid) begin
        blk[hi_k -: 8] <= bus.in_data;
        count          <= count_n;
        if (!bus.in_last) begin
          if (p == 8'd128) begin
            state   <= S_OUT;
            last_r  <= 1'b0;
            pending <= P_NONE;
          end else begin
            idx <= p[6:0];
          end
        end else if (p <= 8'd111) begin
          // Message fits with its length: marker, zero gap already present, length tail.
          blk[hi_p -: 8] <= 8'h80;
          blk[127:0]     <= len_new;
          last_r         <= 1'b1;
          pending        <= P_NONE;
          state          <= S_OUT;
        end else if (p <= 8'd127) begin
          blk[hi_p -: 8] <= 8'h80;
          last_r         <= 1'b0;
          pending        <= P_LEN_ONLY;
          state          <= S_OUT;
        end else begin
          last_r  <= 1'b0;
          pending <= P_MARK_LEN;
          state   <= S_OUT;
        end
      end
    end else if (bus.out_ready) begin
      case (pending)
        P_LEN_ONLY: begin
          blk     <= {896'b0, len_cur};
          last_r  <= 1'b1;
          pending <= P_NONE;
        end
        P_MARK_LEN: begin
          blk     <= {8'h80, 888'b0, len_cur};
          last_r  <= 1'b1;
          pending <= P_NONE;
        end
        default: begin
          // Clearing here guarantees unwritten bytes of the next block read as zero.
          state  <= S_FILL;
          idx    <= '0;
          blk    <= '0;
          last_r <= 1'b0;
          if (last_r) count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha512_padder.sv
// tb/tb_sha512_padder.sv - directed self-checking bench for sha512_padder
module tb_sha512_padder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sha512_padder_if bus ();

  sha512_padder #(.CNT_W(32), .BLOCK_W(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int w = 0; w < 16; w++)
      if (a[1023-64*w -: 64] !== b[1023-64*w -: 64]) return w;
    return 0;
  endfunction

  task automatic send_bytes(input logic [1023:0] msg, input int n, input logic do_last, input string name);
    int w;
    bit timed_out;
    timed_out = 0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[1023-8*i -: 8];
      bus.in_last  = do_last && (i == n - 1);
      w = 0;
      while (!bus.in_ready && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 200) timed_out = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s_send: in_ready stayed low, got timeout, expected acceptance", name);
    end
  endtask

  task automatic recv_block(input logic [1023:0] exp, input logic exp_last, input string name);
    int w;
    int d;
    bus.out_ready = 1'b1;
    w = 0;
    while (!bus.out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (w >= 200) begin
      errors++;
      $display("FAIL %s_timeout: out_valid got 0, expected 1", name);
    end
    checks++;
    if (bus.out_block !== exp) begin
      errors++;
      d = first_diff(bus.out_block, exp);
      $display("FAIL %s_block: word %0d got %h expected %h", name, d,
               bus.out_block[1023-64*d -: 64], exp[1023-64*d -: 64]);
    end
    checks++;
    if (bus.out_last !== exp_last) begin
      errors++;
      $display("FAIL %s_last: got %b expected %b", name, bus.out_last, exp_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got in_ready=%b out_valid=%b out_last=%b expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.out_last);
    end
    checks++;
    if (bus.out_block !== 1024'b0) begin
      errors++;
      $display("FAIL reset_block: got nonzero block, expected all zero");
    end
  endtask

  task automatic test_abc(input string name);
    logic [1023:0] msg;
    msg = {24'h616263, 1000'b0};
    bus.out_ready = 1'b1;
    send_bytes(msg, 3, 1'b1, name);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: out_valid got %b expected 1 one cycle after last byte", name, bus.out_valid);
    end
    recv_block({24'h616263, 8'h80, 864'b0, 128'h18}, 1'b1, name);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: got out_valid=%b in_ready=%b expected 0 1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_hello();
    logic [111:0] txt;
    txt = "Hello SHA-512!";
    bus.out_ready = 1'b1;
    send_bytes({txt, 912'b0}, 14, 1'b1, "hello");
    recv_block({txt, 8'h80, 776'b0, 128'h70}, 1'b1, "hello");
  endtask

  task automatic test_len111();
    bus.out_ready = 1'b1;
    send_bytes({{111{8'hAA}}, 136'b0}, 111, 1'b1, "len111");
    recv_block({{111{8'hAA}}, 8'h80, 128'h378}, 1'b1, "len111");
  endtask

  task automatic test_len112();
    bus.out_ready = 1'b1;
    send_bytes({{112{8'hAA}}, 128'b0}, 112, 1'b1, "len112");
    recv_block({{112{8'hAA}}, 8'h80, 120'b0}, 1'b0, "len112_b1");
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL len112_tail_next: out_valid got %b expected 1", bus.out_valid);
    end
    recv_block({896'b0, 128'h380}, 1'b1, "len112_b2");
  endtask

  task automatic test_len128();
    bus.out_ready = 1'b1;
    send_bytes({128{8'h55}}, 128, 1'b1, "len128");
    recv_block({128{8'h55}}, 1'b0, "len128_b1");
    recv_block({8'h80, 888'b0, 128'h400}, 1'b1, "len128_b2");
  endtask

  task automatic test_backpressure();
    logic [1023:0] exp1;
    exp1 = {{112{8'hAA}}, 8'h80, 120'b0};
    bus.out_ready = 1'b0;
    send_bytes({{112{8'hAA}}, 128'b0}, 112, 1'b1, "bp");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_last !== 1'b0 || bus.out_block !== exp1) begin
        errors++;
        $display("FAIL bp_stall_%0d: got out_valid=%b in_ready=%b out_last=%b block_ok=%b expected 1 0 0 1",
                 c, bus.out_valid, bus.in_ready, bus.out_last, bus.out_block === exp1);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    recv_block(exp1, 1'b0, "bp_b1");
    recv_block({896'b0, 128'h380}, 1'b1, "bp_b2");
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send_bytes({{50{8'h33}}, 624'b0}, 50, 1'b0, "mid");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async_reset: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_abc("abc_after_reset");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_abc("abc");
    test_hello();
    test_len111();
    test_len112();
    test_len128();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
